// File: rtl/byte_stream_packer.sv
// -----------------------------------------------------------------------------
// byte_stream_packer
//
// Purpose:
//   Accepts a byte stream under a valid/ready handshake, packs the bytes
//   little-endian into OUT_BYTES-wide words (first byte in lane 0) and queues
//   the words in a FIFO_DEPTH-entry FIFO. The FIFO head is presented on a
//   valid/ready output port. in_last closes a partial word early; the lanes
//   that were written are flagged in out_keep and unused lanes read as zero.
//
// Parameters:
//   OUT_BYTES   bytes per output word (2..8)
//   FIFO_DEPTH  output word FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_data     input byte
//   in_valid    input byte valid
//   in_last     last byte of packet, closes the word (qualified by in_valid)
//   in_ready    stage can accept a byte this cycle (registered, = !full)
//   out_data    FIFO head word, zero when out_valid is low
//   out_keep    per-lane byte-valid mask of the head word, zero when idle
//   out_valid   FIFO holds at least one word
//   out_ready   downstream accepts the head word
//   fifo_count  number of words held in the FIFO
//   word_count  (PACKER_STATS_EN only) popped words, saturating
//   byte_count  (PACKER_STATS_EN only) popped valid bytes, saturating
//
// Configuration:
//   Define PACKER_STATS_EN to add the word_count / byte_count statistics
//   outputs. Without it those ports and counters are absent and the packer
//   behaves identically.
// -----------------------------------------------------------------------------
module byte_stream_packer #(
    parameter int OUT_BYTES  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [8*OUT_BYTES-1:0]        out_data,
    output logic [OUT_BYTES-1:0]          out_keep,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef PACKER_STATS_EN
    ,
    output logic [15:0]                   word_count,
    output logic [15:0]                   byte_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(OUT_BYTES);
    localparam int WW = 8 * OUT_BYTES;
    localparam logic [IW-1:0] LAST_IDX = IW'(OUT_BYTES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [IW-1:0]        idx_q,    idx_d;
    logic [WW-1:0]        acc_q,    acc_d;
    logic [OUT_BYTES-1:0] keep_q,   keep_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q,  count_d;
    logic                 rdy_q,    rdy_d;

    logic [WW-1:0]        mem_data [FIFO_DEPTH];
    logic [OUT_BYTES-1:0] mem_keep [FIFO_DEPTH];

    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [WW-1:0]        word_w;
    logic [OUT_BYTES-1:0] word_keep_w;

    assign accept     = in_valid && rdy_q;
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid && out_ready;
    assign in_ready   = rdy_q;
    assign fifo_count = count_q;
    assign out_data   = out_valid ? mem_data[rd_ptr_q] : '0;
    assign out_keep   = out_valid ? mem_keep[rd_ptr_q] : '0;

    always_comb begin
        // Word as it would look with the incoming byte merged into lane idx.
        word_w      = acc_q;
        word_keep_w = keep_q;
        for (int l = 0; l < OUT_BYTES; l++) begin
            if (idx_q == IW'(l)) begin
                word_w[8*l +: 8] = in_data;
                word_keep_w[l]   = 1'b1;
            end
        end

        push   = accept && ((idx_q == LAST_IDX) || in_last);

        idx_d  = idx_q;
        acc_d  = acc_q;
        keep_d = keep_q;
        if (accept) begin
            if (push) begin
                idx_d  = '0;
                acc_d  = '0;
                keep_d = '0;
            end else begin
                idx_d  = idx_q + 1'b1;
                acc_d  = word_w;
                keep_d = word_keep_w;
            end
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        // Ready is registered from the next count, so it never depends
        // combinationally on out_ready and a push can never hit a full FIFO.
        rdy_d = (count_d != FULL_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            acc_q    <= '0;
            keep_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            keep_q   <= keep_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
        end
    end

    // Storage needs no reset: entries are only visible through the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= word_w;
            mem_keep[wr_ptr_q] <= word_keep_w;
        end
    end

`ifdef PACKER_STATS_EN
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [15:0] keep_bytes(input logic [OUT_BYTES-1:0] k);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            n = n + 16'(k[i]);
        end
        return n;
    endfunction

    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;

    always_comb begin
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        if (pop) begin
            word_cnt_d = sat_add(word_cnt_q, 16'd1);
            byte_cnt_d = sat_add(byte_cnt_q, keep_bytes(out_keep));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign word_count = word_cnt_q;
    assign byte_count = byte_cnt_q;
`endif

endmodule

// File: tb/tb_byte_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_byte_stream_packer
//
// Scoreboard bench for byte_stream_packer (OUT_BYTES=4, FIFO_DEPTH=4).
// The driver feeds bytes into a queue-based packing model whenever a byte is
// taken; completed words go into an expected-word queue. An independent
// monitor compares every word the DUT presents against the queue head.
// -----------------------------------------------------------------------------
module tb_byte_stream_packer;

    localparam int OB = 4;
    localparam int FD = 4;
    localparam int DW = 8 * OB;

    logic          clk;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [OB-1:0] out_keep;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    fifo_count;
`ifdef PACKER_STATS_EN
    logic [15:0]   word_count;
    logic [15:0]   byte_count;
`endif

    byte_stream_packer #(.OUT_BYTES(OB), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count)
`ifdef PACKER_STATS_EN
        ,
        .word_count (word_count),
        .byte_count (byte_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    cur_bytes[$];
    logic [DW-1:0] exp_data[$];
    logic [OB-1:0] exp_keep[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference packing: collect bytes, close a word when it is full or last.
    task automatic model_accept(input logic [7:0] b, input logic last);
        logic [DW-1:0] w;
        logic [OB-1:0] k;
        cur_bytes.push_back(b);
        if (cur_bytes.size() == OB || last) begin
            w = '0;
            k = '0;
            for (int i = 0; i < cur_bytes.size(); i++) begin
                w[8*i +: 8] = cur_bytes[i];
                k[i]        = 1'b1;
            end
            exp_data.push_back(w);
            exp_keep.push_back(k);
            cur_bytes.delete();
        end
    endtask

    task automatic model_clear();
        cur_bytes.delete();
        exp_data.delete();
        exp_keep.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int waited;
        waited   = 0;
        in_data  = b;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed %0b, expected 1", in_ready);
        end else begin
            model_accept(b, last);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        model_clear();
        repeat (cycles) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    // Monitor: compares the presented head against the scoreboard each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_data.size() == 0) begin
                    check("unexpected_word", 64'(out_data), 64'hDEAD);
                end else begin
                    check("word_data", 64'(out_data), 64'(exp_data[0]));
                    check("word_keep", 64'(out_keep), 64'(exp_keep[0]));
                    if (out_ready) begin
                        void'(exp_data.pop_front());
                        void'(exp_keep.pop_front());
                    end
                end
            end else if (!out_valid) begin
                check("idle_data", 64'(out_data), 64'h0);
                check("idle_keep", 64'(out_keep), 64'h0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic tx_done;

    task automatic run_random(input int nbytes, input bit use_last);
        tx_done = 1'b0;
        fork
            begin
                for (int i = 0; i < nbytes; i++) begin
                    logic lst;
                    lst = use_last ? (($urandom_range(0, 3) == 0) || (i == nbytes - 1)) : 1'b0;
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send_byte(8'($urandom), lst);
                end
                tx_done = 1'b1;
            end
            begin
                int cyc;
                cyc = 0;
                while (!(tx_done && exp_data.size() == 0) && cyc < 5000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    cyc++;
                end
                if (cyc >= 5000) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL drain_timeout: %0d words left, expected 0", exp_data.size());
                end
                out_ready = 1'b0;
            end
        join
        @(posedge clk); #1;
        check("drained_count", 64'(fifo_count), 64'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset held with in_valid toggling.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = ~in_valid;
            @(negedge clk);
            check("rst_in_ready",  64'(in_ready),   64'h0);
            check("rst_out_valid", 64'(out_valid),  64'h0);
            check("rst_count",     64'(fifo_count), 64'h0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("rel_in_ready_pre", 64'(in_ready), 64'h0);
        @(posedge clk); #1;
        check("rel_in_ready_post", 64'(in_ready), 64'h1);

        // Full word.
        out_ready = 1'b1;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        check("full_count",     64'(fifo_count), 64'h1);
        check("full_data",      64'(out_data),   64'hDDCCBBAA);
        check("full_keep",      64'(out_keep),   64'hF);
        @(posedge clk); #1;
        check("full_count_after", 64'(fifo_count), 64'h0);

        // Partial flush, then restart at lane 0.
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        check("part_data", 64'(out_data), 64'h00002211);
        check("part_keep", 64'(out_keep), 64'h3);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        check("restart_data", 64'(out_data), 64'h66554433);
        @(posedge clk); #1;

        // Backpressure fills the FIFO.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 1'b0);
        end
        check("bp_count",    64'(fifo_count), 64'h4);
        check("bp_in_ready", 64'(in_ready),   64'h0);
        in_data  = 8'h10;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_hold_count", 64'(fifo_count), 64'h4);
            check("bp_hold_ready", 64'(in_ready),   64'h0);
            check("bp_head",       64'(out_data),   64'h03020100);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_ready_before_pop", 64'(in_ready), 64'h0);
        @(posedge clk); #1;
        check("bp_ready_after_pop", 64'(in_ready),   64'h1);
        check("bp_count_after_pop", 64'(fifo_count), 64'h3);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("bp_drained", 64'(fifo_count), 64'h0);

        // Reset in the middle of a word with a word waiting.
        out_ready = 1'b0;
        send_byte(8'hE0, 1'b0);
        send_byte(8'hE1, 1'b0);
        send_byte(8'hE2, 1'b0);
        send_byte(8'hE3, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'hF1, 1'b0);
        send_byte(8'hF2, 1'b0);
        check("mid_valid_before", 64'(out_valid), 64'h1);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("mid_valid_drop", 64'(out_valid),  64'h0);
        check("mid_count_drop", 64'(fifo_count), 64'h0);
        check("mid_ready_drop", 64'(in_ready),   64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        check("mid_after_data", 64'(out_data), 64'h04030201);
        check("mid_after_keep", 64'(out_keep), 64'hF);
        @(posedge clk); #1;

        // Wrap-around: 12 full words under random backpressure.
        do_reset(2);
        @(posedge clk); #1;
        run_random(48, 1'b0);
`ifdef PACKER_STATS_EN
        check("stats_words", 64'(word_count), 64'd12);
        check("stats_bytes", 64'(byte_count), 64'd48);
`endif

        // Random packets with random in_last and backpressure.
        run_random(200, 1'b1);
        check("final_queue_empty", 64'(exp_data.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
